tlc_phase_arbiter: RTL



---
 rtl/tlc_phase_arbiter.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/tlc_phase_arbiter.sv
// Request arbiter in front of the traffic light controller: latches pedestrian
// and side-road requests, grants them round-robin, lets emergency preemption
// override everything, and hands one phase at a time to the light controller.
module tlc_phase_arbiter #(
  parameter logic [23:0] TIME_BASE     = 24'd9_999_999,
  parameter logic [9:0]  MIN_GAP       = 10'd100,
  parameter logic [9:0]  SERVE_TIMEOUT = 10'd600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       blink,
  input  logic       ped_main_btn,
  input  logic       ped_side_btn,
  input  logic       veh_side_sense,
  input  logic       emerg_req,
  input  logic       emerg_dir,
  input  logic       phase_ack,
  input  logic       phase_done,
  output logic       phase_valid,
  output logic [2:0] phase_code,
  output logic       phase_abort,
  output logic       ped_main_wait,
  output logic       ped_side_wait,
  output logic       emerg_active,
  output logic       fault,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_SERVE, S_E_ISSUE, S_E_SERVE, S_GAP
  } state_t;

  state_t      state_q, state_d;
  logic [23:0] div_q, div_d;
  logic [2:0]  req_q, req_d;      // previous request inputs, for edge detect
  logic [2:0]  pend_q, pend_d;    // 0 ped_main, 1 ped_side, 2 veh_side
  logic [1:0]  ptr_q, ptr_d;      // last granted source
  logic [1:0]  src_q, src_d;      // source of the phase being issued/served
  logic [2:0]  code_q, code_d;
  logic [9:0]  cnt_q, cnt_d;      // shared timeout / gap counter
  logic        abort_q, abort_d;
  logic        fault_q, fault_d;

  logic        tick;
  logic [2:0]  req_in, rise, clr, reinstate;
  logic [1:0]  cand1, cand2;
  logic        grant_valid;
  logic [1:0]  grant_src;
  logic        timeout;

  function automatic logic [1:0] next_src(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign tick    = (div_q == TIME_BASE);
  assign req_in  = {veh_side_sense, ped_side_btn, ped_main_btn};
  assign rise    = req_in & ~req_q;
  // The counter expires on the tick that would take it to zero.
  assign timeout = tick && (cnt_q <= 10'd1);

  // Round-robin pick among pending sources, starting after the last grant.
  always_comb begin
    cand1       = next_src(ptr_q);
    cand2       = next_src(cand1);
    grant_valid = 1'b1;
    grant_src   = ptr_q;
    if (pend_q[cand1])      grant_src = cand1;
    else if (pend_q[cand2]) grant_src = cand2;
    else if (pend_q[ptr_q]) grant_src = ptr_q;
    else                    grant_valid = 1'b0;
  end

  // Next-state logic for the FSM, counters and request bookkeeping.
  always_comb begin
    state_d   = state_q;
    div_d     = tick ? 24'd0 : div_q + 24'd1;
    req_d     = req_in;
    ptr_d     = ptr_q;
    src_d     = src_q;
    code_d    = code_q;
    cnt_d     = cnt_q;
    abort_d   = 1'b0;
    fault_d   = 1'b0;
    clr       = 3'b000;
    reinstate = 3'b000;

    case (state_q)
      S_IDLE: begin
        if (emerg_req) begin
          state_d = S_E_ISSUE;
          code_d  = emerg_dir ? 3'd5 : 3'd4;
        end else if (!blink && grant_valid) begin
          state_d = S_ISSUE;
          src_d   = grant_src;
          code_d  = {1'b0, grant_src} + 3'd1;
        end
      end
      S_ISSUE: begin
        if (phase_ack) begin
          clr[src_q] = 1'b1;
          ptr_d      = src_q;
          cnt_d      = SERVE_TIMEOUT;
          state_d    = S_SERVE;
        end
      end
      S_SERVE: begin
        if (phase_done) begin
          state_d = S_GAP;
          cnt_d   = MIN_GAP;
        end else if (emerg_req) begin
          // Preempted phase goes back into the queue so it is served later.
          abort_d          = 1'b1;
          reinstate[src_q] = 1'b1;
          state_d          = S_E_ISSUE;
          code_d           = emerg_dir ? 3'd5 : 3'd4;
        end else if (timeout) begin
          fault_d = 1'b1;
          state_d = S_GAP;
          cnt_d   = MIN_GAP;
        end else if (tick) begin
          cnt_d = cnt_q - 10'd1;
        end
      end
      S_E_ISSUE: begin
        if (phase_ack) begin
          cnt_d   = SERVE_TIMEOUT;
          state_d = S_E_SERVE;
        end
      end
      S_E_SERVE: begin
        if (phase_done) begin
          state_d = S_GAP;
          cnt_d   = MIN_GAP;
        end else if (timeout) begin
          fault_d = 1'b1;
          state_d = S_GAP;
          cnt_d   = MIN_GAP;
        end else if (tick) begin
          cnt_d = cnt_q - 10'd1;
        end
      end
      S_GAP: begin
        if (emerg_req) begin
          state_d = S_E_ISSUE;
          code_d  = emerg_dir ? 3'd5 : 3'd4;
        end else if (cnt_q == 10'd0) begin
          state_d = S_IDLE;
        end else if (tick) begin
          cnt_d = cnt_q - 10'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A new edge in the same cycle as its ack keeps the request pending.
    pend_d = (pend_q & ~clr) | rise | reinstate;
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      div_q   <= 24'd0;
      req_q   <= 3'b000;
      pend_q  <= 3'b000;
      ptr_q   <= 2'd2;
      src_q   <= 2'd0;
      code_q  <= 3'd0;
      cnt_q   <= 10'd0;
      abort_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      req_q   <= req_d;
      pend_q  <= pend_d;
      ptr_q   <= ptr_d;
      src_q   <= src_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
      fault_q <= fault_d;
    end
  end

  assign phase_valid   = (state_q == S_ISSUE) || (state_q == S_E_ISSUE);
  assign phase_code    = phase_valid ? code_q : 3'd0;
  assign phase_abort   = abort_q;
  assign fault         = fault_q;
  assign ped_main_wait = pend_q[0];
  assign ped_side_wait = pend_q[1];
  assign emerg_active  = (state_q == S_E_ISSUE) || (state_q == S_E_SERVE);
  assign busy          = (state_q != S_IDLE);

endmodule
